// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the architectural PC, fetches one
// word at a time over a valid/ready request channel, holds the word for the
// decoder until retire, then steers the PC from the decoder's pc_sel.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              PC_SEL_LEN = 3,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [XLEN-1:0]       imem_resp_data,
  output logic [XLEN-1:0]       inst,
  output logic                  inst_valid,
  output logic [XLEN-1:0]       pc,
  input  logic                  retire,
  input  logic [PC_SEL_LEN-1:0] pc_sel,
  input  logic                  br_taken,
  input  logic [XLEN-1:0]       imm_b,
  input  logic [XLEN-1:0]       imm_j,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic                  dec_error,
  output logic                  halted,
  output logic                  misaligned
);

  localparam logic [PC_SEL_LEN-1:0] PC_PLUS_FOUR = PC_SEL_LEN'(0);
  localparam logic [PC_SEL_LEN-1:0] PC_BRANCH    = PC_SEL_LEN'(1);
  localparam logic [PC_SEL_LEN-1:0] PC_JAL       = PC_SEL_LEN'(2);
  localparam logic [PC_SEL_LEN-1:0] PC_JALR      = PC_SEL_LEN'(3);

  typedef enum logic [2:0] {
    S_START,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] next_pc;
  logic            sel_ok;

  // Handshake and status outputs are pure decodes of the state register.
  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_EXEC);
  assign halted         = (state == S_HALT);
  assign imem_addr      = pc;

  // Next-PC candidate from the decoder's select; unknown selects flag sel_ok=0.
  always_comb begin
    next_pc = pc + XLEN'(4);
    sel_ok  = 1'b1;
    case (pc_sel)
      PC_PLUS_FOUR: begin
        next_pc = pc + XLEN'(4);
      end
      PC_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      PC_JAL: begin
        next_pc = pc + imm_j;
      end
      PC_JALR: begin
        next_pc    = rs1_data + imm_i;
        next_pc[0] = 1'b0;
      end
      default: begin
        sel_ok = 1'b0;
      end
    endcase
  end

  // Fetch sequencer: request, wait for data, hold for retire, redirect or halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_START;
      pc         <= RESET_PC;
      inst       <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        S_START: state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            inst  <= imem_resp_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (retire) begin
            if (dec_error || !sel_ok) begin
              state <= S_HALT;
            end else if (next_pc[1:0] != 2'b00) begin
              // Faulting target is not committed; pc keeps the offending inst.
              misaligned <= 1'b1;
              state      <= S_HALT;
            end else begin
              pc    <= next_pc;
              state <= S_REQ;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
